// File: rtl/row_window_writer.sv
// Write side of the 8-row grid window: packs a serial cell stream into rows and
// commits them to 8 circular row slots. Optional commit counter: ROW_WINDOW_WRITER_ROWCNT_EN.
module row_window_writer #(
  parameter int ROW_SIZE = 160
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic                rel,
  output logic [0:ROW_SIZE-1] row1,
  output logic [0:ROW_SIZE-1] row2,
  output logic [0:ROW_SIZE-1] row3,
  output logic [0:ROW_SIZE-1] row4,
  output logic [0:ROW_SIZE-1] row5,
  output logic [0:ROW_SIZE-1] row6,
  output logic [0:ROW_SIZE-1] row7,
  output logic [0:ROW_SIZE-1] row8,
  output logic [2:0]          rd_ptr,
  output logic [2:0]          wr_ptr,
  output logic [3:0]          count,
  output logic                full,
  output logic                empty,
  output logic                grid_done
`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
  ,
  output logic [15:0]         rows_total
`endif
);

  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

  logic [0:ROW_SIZE-1] slot_q [8];
  logic [0:ROW_SIZE-1] slot_d [8];
  logic [0:ROW_SIZE-1] asm_q, asm_d;
  logic [CW-1:0]       col_q, col_d;
  logic [2:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]          wr_ptr_q, wr_ptr_d;
  logic [3:0]          count_q, count_d;
  logic                grid_done_q, grid_done_d;

  logic accept, commit, do_rel;

  // in_ready depends only on stored count, so rel cannot reach it combinationally.
  assign full     = (count_q == 4'd8);
  assign empty    = (count_q == 4'd0);
  assign in_ready = !full;

  assign accept = in_valid && in_ready;
  assign commit = accept && ((col_q == CW'(ROW_SIZE - 1)) || in_last);
  assign do_rel = rel && !empty;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    slot_d      = slot_q;
    asm_d       = asm_q;
    col_d       = col_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    grid_done_d = 1'b0;
    if (accept) begin
      asm_d[col_q] = in_bit;
      col_d        = col_q + 1'b1;
      if (commit) begin
        // Upper positions are already zero, since the assembly register clears on each commit.
        slot_d[wr_ptr_q] = asm_d;
        asm_d            = '0;
        col_d            = '0;
        wr_ptr_d         = wr_ptr_q + 3'd1;
        grid_done_d      = in_last;
      end
    end
    if (do_rel) begin
      slot_d[rd_ptr_q] = '0;
      rd_ptr_d         = rd_ptr_q + 3'd1;
    end
    count_d = count_q + 4'(commit) - 4'(do_rel);
  end

  // NOTE: the row slots are cleared by reset because consumers read all 8 rows directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) slot_q[i] <= '0;
      asm_q       <= '0;
      col_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      grid_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      slot_q      <= slot_d;
      asm_q       <= asm_d;
      col_q       <= col_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      grid_done_q <= grid_done_d;
    end
  end

`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
  logic [15:0] rows_total_q, rows_total_d;

  // The count restarts once a grid is finished; a commit in that same cycle starts the next grid.
  always_comb begin
    if (grid_done_q)
      rows_total_d = 16'(commit);
    else if (commit && rows_total_q != 16'hFFFF)
      rows_total_d = rows_total_q + 16'd1;
    else
      rows_total_d = rows_total_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rows_total_q <= '0;
    else     rows_total_q <= rows_total_d;
  end

  assign rows_total = rows_total_q;
`endif

  assign row1      = slot_q[0];
  assign row2      = slot_q[1];
  assign row3      = slot_q[2];
  assign row4      = slot_q[3];
  assign row5      = slot_q[4];
  assign row6      = slot_q[5];
  assign row7      = slot_q[6];
  assign row8      = slot_q[7];
  assign rd_ptr    = rd_ptr_q;
  assign wr_ptr    = wr_ptr_q;
  assign count     = count_q;
  assign grid_done = grid_done_q;

endmodule

// File: tb/tb_row_window_writer.sv
// Self-checking bench for row_window_writer (ROW_SIZE=4): a window model of stored
// rows is compared on every falling edge, plus hand-computed literal checks.
module tb_row_window_writer;

  localparam int RS = 4;

  logic clk = 1'b0;
  logic rst, in_bit, in_valid, in_ready, in_last, rel;
  logic [0:RS-1] row1_w, row2_w, row3_w, row4_w, row5_w, row6_w, row7_w, row8_w;
  logic [2:0] rd_ptr_w, wr_ptr_w;
  logic [3:0] count_w;
  logic full_w, empty_w, grid_done_w;
`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
  logic [15:0] rows_total_w;
`endif

  row_window_writer #(.ROW_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .rel(rel),
    .row1(row1_w), .row2(row2_w), .row3(row3_w), .row4(row4_w),
    .row5(row5_w), .row6(row6_w), .row7(row7_w), .row8(row8_w),
    .rd_ptr(rd_ptr_w), .wr_ptr(wr_ptr_w), .count(count_w),
    .full(full_w), .empty(empty_w), .grid_done(grid_done_w)
`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
    , .rows_total(rows_total_w)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Window model: stored rows by slot, oldest slot and occupancy; the write slot
  // is derived as (oldest + occupancy) mod 8.
  logic [0:RS-1] m_slots [8];
  int            m_rd, m_count, m_rt;
  bit            m_gd;
  bit            m_partial [$];
  bit            chk_en = 1'b0;

  function automatic int m_wr();
    return (m_rd + m_count) % 8;
  endfunction

  task automatic model_update(input bit b, input bit v, input bit l, input bit r, input bit rs);
    bit accept, commit, released;
    logic [0:RS-1] row;
    int wr;
    if (rs) begin
      for (int i = 0; i < 8; i++) m_slots[i] = '0;
      m_rd = 0; m_count = 0; m_rt = 0; m_gd = 0;
      m_partial.delete();
      return;
    end
    accept   = v && (m_count < 8);
    commit   = accept && ((m_partial.size() == RS - 1) || l);
    released = r && (m_count > 0);
    wr       = m_wr();
    if (accept) m_partial.push_back(b);
    if (commit) begin
      row = '0;
      for (int i = 0; i < m_partial.size(); i++) row[i] = m_partial[i];
      m_slots[wr] = row;
      m_partial.delete();
    end
    if (released) begin
      m_slots[m_rd] = '0;
      m_rd = (m_rd + 1) % 8;
    end
    m_count = m_count + (commit ? 1 : 0) - (released ? 1 : 0);
    if (m_gd) m_rt = commit ? 1 : 0;
    else if (commit && m_rt != 16'hFFFF) m_rt = m_rt + 1;
    m_gd = commit && l;
  endtask

  logic [0:RS-1] dut_rows [8];
  always_comb begin
    dut_rows[0] = row1_w; dut_rows[1] = row2_w; dut_rows[2] = row3_w; dut_rows[3] = row4_w;
    dut_rows[4] = row5_w; dut_rows[5] = row6_w; dut_rows[6] = row7_w; dut_rows[7] = row8_w;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) check($sformatf("row%0d", i + 1), 32'(dut_rows[i]), 32'(m_slots[i]));
      check("rd_ptr",    32'(rd_ptr_w),    32'(m_rd));
      check("wr_ptr",    32'(wr_ptr_w),    32'(m_wr()));
      check("count",     32'(count_w),     32'(m_count));
      check("full",      32'(full_w),      32'(m_count == 8));
      check("empty",     32'(empty_w),     32'(m_count == 0));
      check("in_ready",  32'(in_ready),    32'(m_count != 8));
      check("grid_done", 32'(grid_done_w), 32'(m_gd));
`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
      check("rows_total", 32'(rows_total_w), 32'(m_rt));
`endif
    end
  end

  task automatic step(input bit b, input bit v, input bit l, input bit r, input bit rs);
    in_bit = b; in_valid = v; in_last = l; rel = r; rst = rs;
    @(posedge clk);
    model_update(b, v, l, r, rs);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    idle();
  endtask

  task automatic push_row(input logic [0:RS-1] p, input bit rel_last);
    for (int i = 0; i < RS; i++) step(p[i], 1, 0, (i == RS - 1) ? rel_last : 1'b0, 0);
  endtask

  logic [0:RS-1] pats [9];

  initial begin
    pats = '{4'b1011, 4'b0110, 4'b1110, 4'b0001, 4'b1001, 4'b0101, 4'b1111, 4'b0011, 4'b1101};
    rst = 1'b1; in_bit = 0; in_valid = 0; in_last = 0; rel = 0;
    @(negedge clk);
    do_reset();
    check("lit_reset_count", 32'(count_w), 0);
    check("lit_reset_empty", 32'(empty_w), 1);
    check("lit_reset_ready", 32'(in_ready), 1);

    // Basic row with a valid gap mid-row.
    step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); idle(); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    check("lit_row1_1011", 32'(row1_w), 32'(4'b1011));
    check("lit_wr_after1", 32'(wr_ptr_w), 1);
    check("lit_cnt_after1", 32'(count_w), 1);
    check("lit_rd_after1", 32'(rd_ptr_w), 0);

    // Fill to 8, ignore 9th row while full, release one, then 9th row lands in slot 0.
    do_reset();
    for (int r = 0; r < 8; r++) push_row(pats[r], 0);
    check("lit_full", 32'(full_w), 1);
    check("lit_ready_full", 32'(in_ready), 0);
    check("lit_wr_wrap", 32'(wr_ptr_w), 0);
    push_row(pats[8], 0);
    check("lit_ignored_row1", 32'(row1_w), 32'(4'b1011));
    step(0, 0, 0, 1, 0);
    check("lit_rel_count", 32'(count_w), 7);
    check("lit_rel_rd", 32'(rd_ptr_w), 1);
    check("lit_rel_row1", 32'(row1_w), 0);
    check("lit_rel_ready", 32'(in_ready), 1);
    push_row(pats[8], 0);
    check("lit_row9_row1", 32'(row1_w), 32'(4'b1101));
    check("lit_row9_wr", 32'(wr_ptr_w), 1);
    for (int r = 0; r < 9; r++) step(0, 0, 0, 1, 0); // drain, including one rel at empty

    // in_last after two bits, then a full row starting at col 0.
    do_reset();
    step(1, 1, 0, 0, 0); step(1, 1, 1, 0, 0);
    check("lit_last_row1", 32'(row1_w), 32'(4'b1100));
    check("lit_gd_pulse", 32'(grid_done_w), 1);
    push_row(4'b1001, 0);
    check("lit_gd_clear", 32'(grid_done_w), 0);
    check("lit_row2_after_last", 32'(row2_w), 32'(4'b1001));
    step(1, 1, 1, 0, 0); // in_last at col 0
    check("lit_onebit_row3", 32'(row3_w), 32'(4'b1000));

    // count=3 with commit and rel in the same cycle.
    do_reset();
    push_row(4'b0111, 0); push_row(4'b1010, 0); push_row(4'b1100, 0);
    push_row(4'b0101, 1);
    check("lit_sim_count", 32'(count_w), 3);
    check("lit_sim_rd", 32'(rd_ptr_w), 1);
    check("lit_sim_wr", 32'(wr_ptr_w), 4);
    check("lit_sim_row1", 32'(row1_w), 0);
    check("lit_sim_row4", 32'(row4_w), 32'(4'b0101));

    // rel at empty, then reset mid-row discards the partial row.
    do_reset();
    step(0, 0, 0, 1, 0);
    check("lit_rel_empty_cnt", 32'(count_w), 0);
    check("lit_rel_empty_rd", 32'(rd_ptr_w), 0);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    push_row(4'b0010, 0);
    check("lit_rst_row1", 32'(row1_w), 32'(4'b0010));
    check("lit_rst_wr", 32'(wr_ptr_w), 1);

`ifdef ROW_WINDOW_WRITER_ROWCNT_EN
    do_reset();
    for (int r = 0; r < 10; r++) begin
      push_row(pats[r % 9], (r == 3 || r == 6));
      if (r >= 7) step(0, 0, 0, 1, 0);
    end
    check("lit_rows_total_10", 32'(rows_total_w), 10);
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0);
    check("lit_rt_11", 32'(rows_total_w), 11);
    idle();
    check("lit_rt_zero", 32'(rows_total_w), 0);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
